// File: rtl/verifuck_pkg.sv
// Shared encodings for the verifuck UART transmit arbiter.
package verifuck_pkg;

  // Byte source identifiers; also used as the round-robin history.
  typedef enum logic {
    SRC_CPU = 1'b0,
    SRC_DBG = 1'b1
  } src_e;

  // Arbiter FSM states.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_e;

  // Line terminator that ends a locked line.
  localparam logic [7:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/verifuck_byte_fifo.sv
// Small synchronous FIFO buffering CPU stdout bytes.
// A push is accepted only when the FIFO is not full at the start of the cycle,
// even if a pop happens in the same cycle.
module verifuck_byte_fifo #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DATA_W-1:0]             din,
  output logic [DATA_W-1:0]             dout,
  output logic                          full,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam logic [PtrW-1:0] PtrOne  = PtrW'(1);
  localparam logic [PtrW:0]   CntOne  = (PtrW + 1)'(1);
  localparam logic [PtrW:0]   CntFull = (PtrW + 1)'(FIFO_DEPTH);

  logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
  logic [PtrW-1:0]   r_wr_ptr;
  logic [PtrW-1:0]   r_rd_ptr;
  logic [PtrW:0]     r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  assign full      = (r_count == CntFull);
  assign empty     = (r_count == '0);
  assign count     = r_count;
  assign dout      = r_mem[r_rd_ptr];
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;

  // Storage array; contents are only read when non-empty, so no reset needed.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since the depth is a power of two.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + PtrOne;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + PtrOne;
      end
      unique case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + CntOne;
        2'b01:   r_count <= r_count - CntOne;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART byte transmitter between the CPU stdout
// path (strobe + FIFO) and the debug path (valid/ready).
// Optional macro VERIFUCK_LINE_LOCK_EN: hold the grant on one source until its
// LF byte has been sent, so lines from the two sources never interleave.
module uart_tx_arbiter
  import verifuck_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [DATA_W-1:0] cpu_stdout,
  input  logic              cpu_stdout_en,
  output logic              cpu_stall,
  output logic              cpu_overflow,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              busy
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;

  state_e            r_state;
  state_e            w_state_d;
  src_e              r_last_grant;
  src_e              w_last_grant_d;
  logic [DATA_W-1:0] r_tx_data;
  logic [DATA_W-1:0] w_tx_data_d;
  logic              r_overflow;

  logic              w_fifo_pop;
  logic              w_fifo_full;
  logic              w_fifo_empty;
  logic [DATA_W-1:0] w_fifo_dout;
  logic [CntW-1:0]   w_fifo_count;

  logic              w_cpu_req;
  logic              w_dbg_req;
  logic              w_grant;
  src_e              w_rr_pick;
  src_e              w_pick;
  logic [DATA_W-1:0] w_grant_data;

  verifuck_byte_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (cpu_stdout_en),
    .pop    (w_fifo_pop),
    .din    (cpu_stdout),
    .dout   (w_fifo_dout),
    .full   (w_fifo_full),
    .empty  (w_fifo_empty),
    .count  (w_fifo_count)
  );

  assign w_cpu_req    = !w_fifo_empty;
  assign w_dbg_req    = dbg_valid;
  assign w_grant      = (r_state == ST_IDLE) && (w_cpu_req || w_dbg_req);
  assign w_grant_data = (w_pick == SRC_CPU) ? w_fifo_dout : dbg_data;

  assign cpu_stall    = (w_fifo_count == CntW'(FIFO_DEPTH));
  assign cpu_overflow = r_overflow;
  assign tx_data      = r_tx_data;
  assign busy         = !w_fifo_empty || (r_state == ST_SEND);

  // Plain round-robin choice; on a tie the source not granted last wins.
  always_comb begin
    w_rr_pick = SRC_DBG;
    if (w_cpu_req && w_dbg_req) begin
      w_rr_pick = (r_last_grant == SRC_CPU) ? SRC_DBG : SRC_CPU;
    end else if (w_cpu_req) begin
      w_rr_pick = SRC_CPU;
    end
  end

`ifdef VERIFUCK_LINE_LOCK_EN
  logic r_lock;
  logic w_lock_d;
  src_e r_lock_src;
  src_e w_lock_src_d;
  logic w_lock_hold;

  assign w_lock_hold = r_lock && ((r_lock_src == SRC_CPU) ? w_cpu_req : w_dbg_req);
  assign w_pick      = w_lock_hold ? r_lock_src : w_rr_pick;

  // Lock onto each granted source until its LF byte is granted; an idle
  // cycle without requests means the locked source went quiet, so release.
  always_comb begin
    w_lock_d     = r_lock;
    w_lock_src_d = r_lock_src;
    if (r_state == ST_IDLE) begin
      if (w_grant) begin
        w_lock_d     = (w_grant_data != DATA_W'(ASCII_LF));
        w_lock_src_d = w_pick;
      end else begin
        w_lock_d     = 1'b0;
      end
    end
  end

  // Line-lock state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_lock     <= 1'b0;
      r_lock_src <= SRC_CPU;
    end else begin
      r_lock     <= w_lock_d;
      r_lock_src <= w_lock_src_d;
    end
  end
`else
  assign w_pick = w_rr_pick;
`endif

  // FSM next-state, grant side effects and handshake outputs.
  always_comb begin
    w_state_d      = r_state;
    w_last_grant_d = r_last_grant;
    w_tx_data_d    = r_tx_data;
    w_fifo_pop     = 1'b0;
    dbg_ready      = 1'b0;
    tx_valid       = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_grant) begin
          w_state_d      = ST_SEND;
          w_last_grant_d = w_pick;
          w_tx_data_d    = w_grant_data;
          if (w_pick == SRC_CPU) begin
            w_fifo_pop = 1'b1;
          end else begin
            dbg_ready  = 1'b1;
          end
        end
      end
      ST_SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          w_state_d = ST_IDLE;
        end
      end
    endcase
  end

  // FSM, grant history, held byte and sticky overflow flag.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_last_grant <= SRC_DBG;
      r_tx_data    <= '0;
      r_overflow   <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_last_grant <= w_last_grant_d;
      r_tx_data    <= w_tx_data_d;
      r_overflow   <= r_overflow || (cpu_stdout_en && w_fifo_full);
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (DATA_W=8, FIFO_DEPTH=4).
module tb_uart_tx_arbiter;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] cpu_stdout = 8'h00;
  logic       cpu_stdout_en = 1'b0;
  logic       cpu_stall;
  logic       cpu_overflow;
  logic [7:0] dbg_data = 8'h00;
  logic       dbg_valid = 1'b0;
  logic       dbg_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] tx_q[$];
  logic [7:0] exp_q[$];

  uart_tx_arbiter #(
    .DATA_W     (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .cpu_stdout    (cpu_stdout),
    .cpu_stdout_en (cpu_stdout_en),
    .cpu_stall     (cpu_stall),
    .cpu_overflow  (cpu_overflow),
    .dbg_data      (dbg_data),
    .dbg_valid     (dbg_valid),
    .dbg_ready     (dbg_ready),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Record every byte handed to the serializer.
  always @(posedge clk) begin
    if (resetn && tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] b);
    cpu_stdout_en = 1'b1;
    cpu_stdout    = b;
    tick();
    cpu_stdout_en = 1'b0;
  endtask

  task automatic wait_q(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) tick();
  endtask

  task automatic check_q(input string tag);
    check_eq({tag, "_len"}, tx_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      check_eq(tag, (i < tx_q.size()) ? {24'h0, tx_q[i]} : 32'hFFFF_FFFF, {24'h0, exp_q[i]});
    end
  endtask

  task automatic dbg_send(input logic [7:0] b);
    logic got;
    got       = 1'b0;
    dbg_valid = 1'b1;
    dbg_data  = b;
    for (int i = 0; i < 40 && !got; i++) begin
      #1;
      if (dbg_ready) got = 1'b1;
      tick();
    end
    dbg_valid = 1'b0;
    check_eq("dbg_accept", got, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_tx_valid", tx_valid, 0);
    check_eq("rst_tx_data", tx_data, 0);
    check_eq("rst_dbg_ready", dbg_ready, 0);
    check_eq("rst_stall", cpu_stall, 0);
    check_eq("rst_overflow", cpu_overflow, 0);
    check_eq("rst_busy", busy, 0);
    resetn = 1'b1;
    tick();

    // CPU bytes 0x48, 0x69 with tx_ready held high
    tx_ready = 1'b1;
    tx_q.delete();
    cpu_stdout_en = 1'b1;
    cpu_stdout    = 8'h48;
    tick();
    cpu_stdout = 8'h69;
    #1 check_eq("t1_valid_n1", tx_valid, 0);
    tick();
    cpu_stdout_en = 1'b0;
    check_eq("t1_valid_n2", tx_valid, 1);
    check_eq("t1_data_n2", tx_data, 8'h48);
    wait_q(2, 20);
    exp_q = {8'h48, 8'h69};
    check_q("t1_order");
    check_eq("t1_busy_end", busy, 0);

    // Fill and overflow, with a debug byte parked in SEND
    tx_ready = 1'b0;
    tx_q.delete();
    dbg_valid = 1'b1;
    dbg_data  = 8'h7E;
    #1 check_eq("t2_dbg_grant", dbg_ready, 1);
    tick();
    dbg_valid = 1'b0;
    check_eq("t2_send", tx_valid, 1);
    for (int i = 0; i < 5; i++) begin
      cpu_stdout_en = 1'b1;
      cpu_stdout    = 8'(8'h41 + i);
      if (i == 3) #1 check_eq("t2_stall_before4", cpu_stall, 0);
      if (i == 4) #1 check_eq("t2_stall_after4", cpu_stall, 1);
      tick();
    end
    cpu_stdout_en = 1'b0;
    check_eq("t2_overflow", cpu_overflow, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_eq("t2_hold_valid", tx_valid, 1);
      check_eq("t2_hold_data", tx_data, 8'h7E);
      check_eq("t2_hold_stall", cpu_stall, 1);
    end
    tx_ready = 1'b1;
    wait_q(5, 40);
    exp_q = {8'h7E, 8'h41, 8'h42, 8'h43, 8'h44};
    repeat (4) tick();
    check_q("t2_order");
    check_eq("t2_sticky", cpu_overflow, 1);

    // Reset while a byte is held in SEND
    tx_ready = 1'b0;
    push(8'h99);
    tick();
    check_eq("t3_send", tx_valid, 1);
    resetn = 1'b0;
    #1;
    check_eq("t3_rst_valid", tx_valid, 0);
    check_eq("t3_rst_data", tx_data, 0);
    check_eq("t3_rst_busy", busy, 0);
    check_eq("t3_rst_ovf", cpu_overflow, 0);
    check_eq("t3_rst_stall", cpu_stall, 0);
    tick();
    resetn = 1'b1;
    tx_q.delete();
    tx_ready = 1'b1;
    push(8'hC1);
    dbg_valid = 1'b1;
    dbg_data  = 8'h0A;
    #1 check_eq("t3_tie_cpu", dbg_ready, 0);
    tick();
    dbg_send(8'h0A);
    wait_q(2, 20);
    exp_q = {8'hC1, 8'h0A};
    check_q("t3_order");

    // Contention between FIFO and debug source
    tx_q.delete();
    fork
      begin
        push(8'h31);
`ifdef VERIFUCK_LINE_LOCK_EN
        push(8'h0A);
`else
        push(8'h32);
`endif
      end
      begin
        tick();
        dbg_send(8'h61);
        dbg_send(8'h62);
      end
    join
    wait_q(4, 40);
`ifdef VERIFUCK_LINE_LOCK_EN
    exp_q = {8'h31, 8'h0A, 8'h61, 8'h62};
`else
    exp_q = {8'h31, 8'h61, 8'h32, 8'h62};
`endif
    check_q("t4_order");

    // Backpressure: hold tx_ready low for 10 cycles in SEND
    tx_q.delete();
    tx_ready = 1'b0;
    push(8'h5A);
    tick();
    push(8'h5B);
    dbg_valid = 1'b1;
    dbg_data  = 8'h77;
    for (int i = 0; i < 10; i++) begin
      #1;
      check_eq("t5_valid", tx_valid, 1);
      check_eq("t5_data", tx_data, 8'h5A);
      check_eq("t5_no_dbg_ready", dbg_ready, 0);
      tick();
    end
    tx_ready = 1'b1;
    dbg_send(8'h77);
    wait_q(3, 30);
`ifdef VERIFUCK_LINE_LOCK_EN
    exp_q = {8'h5A, 8'h5B, 8'h77};
`else
    exp_q = {8'h5A, 8'h77, 8'h5B};
`endif
    check_q("t5_order");

    // Push while full in the same cycle as a pop
    check_eq("t6_ovf_clear", cpu_overflow, 0);
    tx_q.delete();
    tx_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(8'(8'hE1 + i));
    check_eq("t6_full", cpu_stall, 1);
    tx_ready = 1'b1;
    tick();
    cpu_stdout_en = 1'b1;
    cpu_stdout    = 8'hE6;
    #1 check_eq("t6_full_at_pop", cpu_stall, 1);
    tick();
    cpu_stdout_en = 1'b0;
    check_eq("t6_ovf_set", cpu_overflow, 1);
    check_eq("t6_count3", cpu_stall, 0);
    wait_q(5, 40);
    repeat (4) tick();
    exp_q = {8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5};
    check_q("t6_order");
    check_eq("t6_busy_end", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single UART byte transmitter between two byte sources.
  - CPU stdout path: one-cycle `stdout_en` strobe plus `stdout` byte.
  - Debug/monitor path: valid/ready handshake.
- Buffers CPU bytes in a small FIFO, so the CPU only stalls when the FIFO is full.
- Arbitrates round-robin and presents one byte at a time to the transmitter on a valid/ready interface.
- Sits between the core and the UART TX serializer inside the top-level `verifuck`.

Parameters:
- DATA_W, 8: byte width on all data ports.
- FIFO_DEPTH, 4: CPU stdout FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single system clock, rising edge.
- resetn  in  1  asynchronous, active-low reset.
- cpu_stdout  in  DATA_W  CPU output byte, sampled when cpu_stdout_en=1.
- cpu_stdout_en  in  1  one-cycle push strobe.
- cpu_stall  out  1  FIFO full; the CPU must hold off further pushes.
- cpu_overflow  out  1  sticky flag: a push was dropped.
- dbg_data  in  DATA_W  debug byte.
- dbg_valid  in  1  debug byte offered.
- dbg_ready  out  1  debug byte accepted this cycle.
- tx_data  out  DATA_W  byte to the UART serializer.
- tx_valid  out  1  tx_data valid.
- tx_ready  in  1  serializer accepts the byte.
- busy  out  1  high while FIFO is non-empty or the FSM is in SEND.

Behaviour:
- Reset (asynchronous, effective immediately on resetn=0):
  - Outputs: tx_valid=0, tx_data=0, dbg_ready=0, cpu_stall=0, cpu_overflow=0, busy=0.
  - FIFO emptied; FSM=IDLE; last_grant=SRC_DBG, so the CPU wins the first tie.
  - Reset mid-SEND discards the held byte and drops tx_valid at once.
- FIFO push:
  - A strobe is accepted if the FIFO is not full at the start of that cycle.
  - A strobe while full is dropped and sets cpu_overflow until the next reset.
  - A simultaneous pop does not make room for a push in the same cycle.
  - Pointers wrap modulo FIFO_DEPTH; occupancy counter is log2(FIFO_DEPTH)+1 bits.
- cpu_stall is combinational: stall = (count == FIFO_DEPTH).
- FSM states:
  - IDLE: tx_valid=0.
    - Requesters are cpu_req = FIFO non-empty and dbg_req = dbg_valid.
    - Exactly one requester: grant it.
    - Both requesting: grant the one that is not last_grant.
    - On grant: load tx_data (CPU grant pops the FIFO head; debug grant drives dbg_ready=1 combinationally that cycle), update last_grant, go to SEND.
  - SEND: tx_valid=1, tx_data held stable.
    - On tx_valid&&tx_ready, go to IDLE; tx_valid is low next cycle.
    - No new grant is made in SEND.
- dbg_ready is asserted only in IDLE when debug is granted; never in SEND.
- Latency:
  - CPU push in cycle N: earliest tx_valid is N+2.
  - Debug byte with dbg_valid in IDLE at cycle M: tx_valid at M+1.
  - Throughput is at most one byte per 2 cycles.
- Data integrity: bytes from each source leave in arrival order; no byte is duplicated or lost except on overflow.
- Reg tx_ready outside SEND is ignored.

Optional Feature:
- Macro: VERIFUCK_LINE_LOCK_EN.
- Defined:
  - After a grant, the arbiter keeps granting the same source while it keeps requesting, until that source's byte 0x0A has been accepted.
  - Then round-robin resumes.
  - If the locked source stops requesting, the lock is released immediately.
  - Effect: lines from the two sources never interleave.
- Undefined: pure per-byte round-robin as above.

Decomposition:
- Package verifuck_pkg holds:
  - Source encoding: SRC_CPU=0, SRC_DBG=1.
  - FSM state encoding: ST_IDLE, ST_SEND.
  - Constant ASCII_LF=8'h0A.
- One sub-module: verifuck_byte_fifo (parameters DATA_W, FIFO_DEPTH).
  - Interface: push, pop, din, dout, full, empty, count.

Test Plan:
- CPU pushes 0x48, 0x69; tx_ready=1 constant -> tx_data 0x48 then 0x69; first tx_valid 2 cycles after the first strobe; busy low after the final handshake.
- FIFO fill and overflow (FIFO_DEPTH=4, tx_ready=0):
  - 5 strobes 0x41..0x45 -> cpu_stall rises after the 4th push, 0x45 dropped, cpu_overflow=1 and sticky.
  - After releasing tx_ready -> 0x41..0x44 emitted in order.
- Contention: FIFO holds 0x31,0x32 and dbg_valid holds 0x61 then 0x62 -> output order 0x31,0x61,0x32,0x62.
  - With VERIFUCK_LINE_LOCK_EN, a FIFO holding 0x31,0x0A keeps the grant and yields 0x31,0x0A,0x61,0x62.
- Backpressure: tx_ready held low 10 cycles in SEND -> tx_data stable, no dbg_ready pulse, FIFO count unchanged.
- Reset mid-SEND: resetn low for 1 cycle while tx_valid=1 -> tx_valid=0 immediately, FIFO empty, cpu_overflow=0; first post-reset tie is granted to the CPU.
- Simultaneous push and pop when full -> push dropped, cpu_overflow set, count drops to 3.
